// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero detector and its restore block.
package lzd_pkg;

    localparam int unsigned LZD_WIDTH = 8;
    localparam int unsigned LZD_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lzd_restore_state_t;

endpackage

// File: rtl/lzd_down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero rather than wrapping.
module lzd_down_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/lzd_restore.sv
// Sequential LZD inverse: shifts the operand right one bit per clock, cnt times.
// Define LZD_RESTORE_STICKY_EN to add the sticky (OR of shifted-out bits) output.
module lzd_restore
    import lzd_pkg::*;
#(
    parameter int unsigned WIDTH = LZD_WIDTH,
    parameter int unsigned CNT_W = LZD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
`ifdef LZD_RESTORE_STICKY_EN
    ,
    output logic             sticky
`endif
);

    lzd_restore_state_t state;
    logic [CNT_W-1:0]   load_cnt;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;

    // Counts beyond WIDTH clear every bit anyway, so clamp them to WIDTH.
    always_comb begin
        load_cnt = (cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt;
        cnt_load = (state == IDLE) && en;
        cnt_dec  = (state == SHIFT) && !cnt_zero;
    end

    lzd_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (load_cnt),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef LZD_RESTORE_STICKY_EN
            sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        out   <= in;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef LZD_RESTORE_STICKY_EN
                        sticky <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_zero) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        out <= out >> 1;
`ifdef LZD_RESTORE_STICKY_EN
                        sticky <= sticky | out[0];
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzd_restore.sv
// Self-checking bench for lzd_restore: directed cases plus randomized traffic
// checked every cycle against an operation-level reference model.
module tb_lzd_restore;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] cnt = '0;
    logic [7:0] out;
    logic       done;
    logic       busy;
`ifdef LZD_RESTORE_STICKY_EN
    logic       sticky;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lzd_restore #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (din),
        .cnt    (cnt),
        .out    (out),
        .done   (done),
        .busy   (busy)
`ifdef LZD_RESTORE_STICKY_EN
        ,
        .sticky (sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Operation-level model: one accepted request finishes n+1 edges later,
    // with result in >> n and the OR of the n discarded bits.
    int         ecount = 0;
    bit         m_busy = 1'b0;
    int         m_end = 0;
    logic [7:0] m_res = '0;
    logic       m_st = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_res  = '0;
            m_st   = 1'b0;
        end else begin
            ecount++;
            if (m_busy) begin
                if (ecount == m_end) m_busy = 1'b0;
            end else if (en) begin
                int         n;
                logic [8:0] mask;
                n      = (cnt > 4'd8) ? 8 : int'(cnt);
                mask   = (9'd1 << n) - 9'd1;
                m_res  = din >> n;
                m_st   = (din & mask[7:0]) != 8'd0;
                m_end  = ecount + n + 2;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_done;
            e_done = m_busy && (ecount == m_end - 1);
            check("busy", busy, m_busy);
            check("done", done, e_done);
            if (!m_busy || e_done) begin
                check("out", out, m_res);
`ifdef LZD_RESTORE_STICKY_EN
                check("sticky", sticky, m_st);
`endif
            end
        end
    end

    // Issue one request and measure edges from acceptance to the done pulse.
    task automatic run_op(input string name, input logic [7:0] v, input logic [3:0] c,
                          input logic [7:0] exp_out, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        en = 1'b1; din = v; cnt = c;
        @(posedge clk);
        #1 en = 1'b0; din = $urandom; cnt = $urandom;
        lat = 0; seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk);
            lat++;
            #1 if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_out"}, out, exp_out);
        @(posedge clk);
        #1 check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        int dones;
        #2 rst_n = 1'b0;
        #1;
        check("reset_out", out, 8'h00);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
`ifdef LZD_RESTORE_STICKY_EN
        check("reset_sticky", sticky, 1'b0);
`endif
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        run_op("normal", 8'b11100000, 4'd5, 8'b00000111, 6);
        run_op("zero_cnt", 8'b10000000, 4'd0, 8'b10000000, 1);
        run_op("all_zero", 8'b10000000, 4'd8, 8'b00000000, 9);
        run_op("saturate", 8'b10000000, 4'd12, 8'b00000000, 9);

        // Second request presented during SHIFT must be dropped entirely.
        @(negedge clk);
        en = 1'b1; din = 8'b11000000; cnt = 4'd1;
        @(posedge clk);
        #1 cnt = 4'd3; din = 8'hFF;
        @(posedge clk);
        #1 en = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (done) begin
                dones++;
                check("busyreq_out", out, 8'b01100000);
            end
        end
        check("busyreq_done_count", dones, 1);

        // Reset after three shifts discards the operation.
        @(negedge clk);
        en = 1'b1; din = 8'hFF; cnt = 4'd6;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out", out, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("midrst_no_done", dones, 0);

`ifdef LZD_RESTORE_STICKY_EN
        run_op("sticky1", 8'b10110000, 4'd5, 8'b00000101, 6);
        check("sticky1_val", sticky, 1'b1);
        run_op("sticky0", 8'b10000000, 4'd3, 8'b00010000, 4);
        check("sticky0_val", sticky, 1'b0);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            en  = ($urandom_range(0, 3) == 0);
            din = $urandom;
            cnt = 4'($urandom_range(0, 15));
            rst_n = (i != 777);
        end
        @(negedge clk);
        #1 en = 1'b0; rst_n = 1'b1;
        repeat (14) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
